// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states,
// funct3 width codes, arbitration priority values and extension helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] BT_B  = 3'b000;
    localparam logic [2:0] BT_H  = 3'b001;
    localparam logic [2:0] BT_W  = 3'b010;
    localparam logic [2:0] BT_BU = 3'b100;
    localparam logic [2:0] BT_HU = 3'b101;

    localparam logic PRI_FETCH = 1'b0;
    localparam logic PRI_DATA  = 1'b1;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational byte-lane alignment: byte enables, store lane replication,
// load lane selection with sign/zero extension, and illegal-access detection.
module mem_port_arbiter_lsu_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  byt_typ_i,
    input  logic [1:0]  off_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        illegal_o
);

    logic [31:0] rshift_s;

    assign rshift_s = rdata_i >> {off_i, 3'b000};

    // Decode the access width into lanes; unknown widths stay illegal.
    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = 32'h0000_0000;
        rdata_o   = 32'h0000_0000;
        illegal_o = 1'b1;
        case (byt_typ_i)
            BT_B: begin
                be_o      = 4'b0001 << off_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = sext8(rshift_s[7:0]);
                illegal_o = 1'b0;
            end
            BT_H: begin
                be_o      = 4'b0011 << off_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = sext16(rshift_s[15:0]);
                illegal_o = off_i[0];
            end
            BT_W: begin
                be_o      = 4'b1111;
                wdata_o   = wdata_i;
                rdata_o   = rshift_s;
                illegal_o = (off_i != 2'b00);
            end
            // Unsigned widths exist only for loads.
            BT_BU: begin
                be_o      = 4'b0001 << off_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = {24'h00_0000, rshift_s[7:0]};
                illegal_o = we_i;
            end
            BT_HU: begin
                be_o      = 4'b0011 << off_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {16'h0000, rshift_s[15:0]};
                illegal_o = we_i | off_i[0];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one fixed-latency
// single-port memory, with alternating priority on ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [2:0]    dm_byt_typ,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          pri_q, pri_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          sel_fetch_q, we_q, err_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q, if_rdata_q, dm_rdata_q;
    logic [2:0]    bt_q;

    logic          win_fetch_s, req_any_s, idle_s, capture_s;
    logic [2:0]    al_bt_s;
    logic [1:0]    al_off_s;
    logic          al_we_s, al_illegal_s;
    logic [31:0]   al_wdata_s, al_wdata_lane_s, al_rdata_s;
    logic [3:0]    al_be_s;

    assign idle_s      = (state_q == ST_IDLE);
    assign req_any_s   = if_req | dm_req;
    assign win_fetch_s = if_req & (~dm_req | (pri_q == PRI_FETCH));
    assign capture_s   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // In IDLE the aligner judges the live winner; afterwards it serves the latched access.
    always_comb begin
        if (!idle_s) begin
            al_bt_s    = bt_q;
            al_off_s   = addr_q[1:0];
            al_we_s    = we_q;
            al_wdata_s = wdata_q;
        end else if (win_fetch_s) begin
            al_bt_s    = BT_W;
            al_off_s   = if_addr[1:0];
            al_we_s    = 1'b0;
            al_wdata_s = 32'h0000_0000;
        end else begin
            al_bt_s    = dm_byt_typ;
            al_off_s   = dm_addr[1:0];
            al_we_s    = dm_we;
            al_wdata_s = dm_wdata;
        end
    end

    mem_port_arbiter_lsu_align u_align (
        .byt_typ_i (al_bt_s),
        .off_i     (al_off_s),
        .we_i      (al_we_s),
        .wdata_i   (al_wdata_s),
        .rdata_i   (mem_rdata),
        .be_o      (al_be_s),
        .wdata_o   (al_wdata_lane_s),
        .rdata_o   (al_rdata_s),
        .illegal_o (al_illegal_s)
    );

    // State, priority and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pri_q   <= PRI_DATA;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; illegal accesses skip the memory entirely.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    pri_d   = win_fetch_s ? PRI_DATA : PRI_FETCH;
                    state_d = al_illegal_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the granted access in IDLE and capture read data when it arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_fetch_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            bt_q        <= 3'b000;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'h0000_0000;
            dm_rdata_q  <= 32'h0000_0000;
        end else if (idle_s && req_any_s) begin
            sel_fetch_q <= win_fetch_s;
            addr_q      <= win_fetch_s ? if_addr : dm_addr;
            we_q        <= al_we_s;
            wdata_q     <= al_wdata_s;
            bt_q        <= al_bt_s;
            err_q       <= al_illegal_s;
        end else if (capture_s && sel_fetch_q) begin
            if_rdata_q  <= al_rdata_s;
        end else if (capture_s) begin
            dm_rdata_q  <= al_rdata_s;
        end
    end

    // Output decode from the current state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0000_0000;
        if_ack    = 1'b0;
        if_err    = 1'b0;
        dm_ack    = 1'b0;
        dm_err    = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[AW-1:2], 2'b00};
                mem_be    = al_be_s;
                mem_wdata = we_q ? al_wdata_lane_s : 32'h0000_0000;
            end
            ST_RESP: begin
                if_ack = sel_fetch_q;
                if_err = sel_fetch_q & err_q;
                dm_ack = ~sel_fetch_q;
                dm_err = ~sel_fetch_q & err_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule
